// File: rtl/sync_fifo_bram_ctrl_if.sv
// sync_fifo_bram_ctrl_if: producer/consumer handshake and status of the BRAM-backed FIFO
interface sync_fifo_bram_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    logic                  fifo_full_n;
    logic                  fifo_rd_en;
    logic                  fifo_empty_n;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_valid;
    logic                  fifo_almost_full;
    logic                  fifo_almost_empty;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  fifo_err_clr;
    logic                  fifo_overflow;
    logic                  fifo_underflow;

    modport master (
        output fifo_wr_en, fifo_wr_data, fifo_rd_en, fifo_err_clr,
        input  fifo_full_n, fifo_empty_n, fifo_rd_data, fifo_rd_valid,
               fifo_almost_full, fifo_almost_empty, cnt, fifo_overflow, fifo_underflow
    );

    modport slave (
        input  fifo_wr_en, fifo_wr_data, fifo_rd_en, fifo_err_clr,
        output fifo_full_n, fifo_empty_n, fifo_rd_data, fifo_rd_valid,
               fifo_almost_full, fifo_almost_empty, cnt, fifo_overflow, fifo_underflow
    );
endinterface

// File: rtl/sync_fifo_bram_ctrl.sv
// sync_fifo_bram_ctrl: synchronous FIFO controller driving an external simple-dual-port BRAM.
// Sticky overflow/underflow flags are built only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_bram_ctrl #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RD_LATENCY = 1,
    parameter int AF_MARGIN  = 2,
    parameter int AE_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bram_rst_busy,
    sync_fifo_bram_ctrl_if.slave  fifo,
    output logic                  bram_clka,
    output logic                  bram_rsta,
    output logic                  bram_ena,
    output logic                  bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [DATA_WIDTH-1:0] bram_dina,
    output logic                  bram_clkb,
    output logic                  bram_rstb,
    output logic                  bram_enb,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [DATA_WIDTH-1:0] bram_doutb
);
    localparam logic [ADDR_WIDTH:0]   FULL   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_LVL = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_WIDTH:0]   AE_LVL = (ADDR_WIDTH+1)'(AE_MARGIN);
    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(DEPTH - 1);

    logic                  internal_reset;
    logic                  ready;
    logic                  rd_accept;
    logic                  wr_accept;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [1:0]            vld;

    assign internal_reset = reset | bram_rst_busy;
    assign rd_accept = fifo.fifo_rd_en & fifo.fifo_empty_n;
    assign wr_accept = fifo.fifo_wr_en & (fifo.fifo_full_n | rd_accept);

    // Flags come only from registers, so no enable ever reaches full_n/empty_n combinationally
    assign fifo.fifo_full_n       = (fifo.cnt != FULL) & ready;
    assign fifo.fifo_empty_n      = (fifo.cnt != '0) & ready;
    assign fifo.fifo_almost_full  = fifo.cnt >= AF_LVL;
    assign fifo.fifo_almost_empty = fifo.cnt <= AE_LVL;
    assign fifo.fifo_rd_data      = bram_doutb;
    assign fifo.fifo_rd_valid     = RD_LATENCY == 2 ? vld[1] : vld[0];

    assign bram_clka  = clk;
    assign bram_rsta  = reset;
    assign bram_ena   = wr_accept;
    assign bram_wea   = 1'b1;
    assign bram_addra = wr_ptr;
    assign bram_dina  = fifo.fifo_wr_data;
    assign bram_clkb  = clk;
    assign bram_rstb  = reset;
    assign bram_enb   = rd_accept;
    assign bram_addrb = rd_ptr;

    always_ff @(posedge clk) begin
        if (internal_reset) begin
            ready    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo.cnt <= '0;
            vld      <= '0;
        end else begin
            ready    <= 1'b1;
            wr_ptr   <= wr_accept ? (wr_ptr == LAST ? '0 : wr_ptr + 1'b1) : wr_ptr;
            rd_ptr   <= rd_accept ? (rd_ptr == LAST ? '0 : rd_ptr + 1'b1) : rd_ptr;
            fifo.cnt <= (wr_accept & ~rd_accept) ? fifo.cnt + 1'b1 :
                        (rd_accept & ~wr_accept) ? fifo.cnt - 1'b1 : fifo.cnt;
            vld      <= {vld[0], rd_accept};
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (internal_reset | fifo.fifo_err_clr) begin
            fifo.fifo_overflow  <= 1'b0;
            fifo.fifo_underflow <= 1'b0;
        end else begin
            fifo.fifo_overflow  <= fifo.fifo_overflow | (fifo.fifo_wr_en & ~wr_accept & ready);
            fifo.fifo_underflow <= fifo.fifo_underflow | (fifo.fifo_rd_en & ~rd_accept & ready);
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr      = fifo.fifo_err_clr;
    assign fifo.fifo_overflow  = 1'b0;
    assign fifo.fifo_underflow = 1'b0;
`endif
endmodule
